// File: rtl/min_sequencer.sv
// Serial minimum finder: streams N operands through one shared 2-input min datapath
// and reports the minimum value plus the index of its first occurrence.

module min_calculator_2num (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_min,
  output logic       o_b_less
);
  // Strict compare so equal values keep the earlier operand.
  assign o_b_less = (i_b < i_a);
  assign o_min    = o_b_less ? i_b : i_a;
endmodule

module min_sequencer #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_in_valid,
  input  logic [W-1:0]   i_in_data,
  output logic           o_in_ready,
  output logic           o_busy,
  output logic           o_out_valid,
  output logic [2*W-1:0] o_out_min,
  output logic [3:0]     o_out_idx,
  input  logic           i_out_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     r_state, w_nextState;
  logic [3:0] r_cur, r_idx, r_cnt;
  logic [3:0] w_nextCur, w_nextIdx, w_nextCnt;
  logic [3:0] w_min;
  logic       w_less;

  min_calculator_2num u_min (
    .i_a      (r_cur),
    .i_b      (i_in_data),
    .o_min    (w_min),
    .o_b_less (w_less)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cur   <= 4'd0;
      r_idx   <= 4'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cur   <= w_nextCur;
      r_idx   <= w_nextIdx;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCur   = r_cur;
    w_nextIdx   = r_idx;
    w_nextCnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = COLLECT;
          w_nextCnt   = 4'd0;
        end
      end
      COLLECT: begin
        // in_ready is constant high here, so in_valid alone qualifies an accept.
        if (i_in_valid) begin
          if (r_cnt == 4'd0) begin
            w_nextCur = i_in_data;
            w_nextIdx = 4'd0;
          end else if (w_less) begin
            w_nextCur = w_min;
            w_nextIdx = r_cnt;
          end
          w_nextCnt = r_cnt + 4'd1;
          if (r_cnt == 4'(N - 1)) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        if (i_out_ack) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign o_in_ready  = (r_state == COLLECT);
  assign o_busy      = (r_state == COLLECT) || (r_state == DONE);
  assign o_out_valid = (r_state == DONE);
  assign o_out_min   = {{W{1'b0}}, r_cur};
  assign o_out_idx   = r_idx;

endmodule

// File: tb/tb_min_sequencer.sv
// Directed bench for min_sequencer: table-driven batches on N=4 plus hand-written
// sequences for bubbles, held results, mid-batch reset and N=2 / N=15 instances.

module tb_min_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       outAck;
  logic [3:0] inData;
  logic       start    [3];
  logic       inReady  [3];
  logic       busy     [3];
  logic       outValid [3];
  logic [7:0] outMin   [3];
  logic [3:0] outIdx   [3];

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [14:0][3:0] ops;
    int               expMin;
    int               expIdx;
    string            name;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  min_sequencer #(.N(4), .W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_in_valid(inValid),
    .i_in_data(inData), .o_in_ready(inReady[0]), .o_busy(busy[0]),
    .o_out_valid(outValid[0]), .o_out_min(outMin[0]), .o_out_idx(outIdx[0]),
    .i_out_ack(outAck)
  );

  min_sequencer #(.N(2), .W(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_in_valid(inValid),
    .i_in_data(inData), .o_in_ready(inReady[1]), .o_busy(busy[1]),
    .o_out_valid(outValid[1]), .o_out_min(outMin[1]), .o_out_idx(outIdx[1]),
    .i_out_ack(outAck)
  );

  min_sequencer #(.N(15), .W(4)) dut15 (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_in_valid(inValid),
    .i_in_data(inData), .o_in_ready(inReady[2]), .o_busy(busy[2]),
    .o_out_valid(outValid[2]), .o_out_min(outMin[2]), .o_out_idx(outIdx[2]),
    .i_out_ack(outAck)
  );

  function automatic logic [14:0][3:0] mk4(input int a, input int b, input int c, input int d);
    logic [14:0][3:0] r;
    r    = '0;
    r[0] = 4'(a);
    r[1] = 4'(b);
    r[2] = 4'(c);
    r[3] = 4'(d);
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vecCount++;
    if (act != exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start, then stream n operands with in_valid held high; leaves DUT in DONE.
  task automatic collect(input int sel, input int n, input logic [14:0][3:0] ops, input string name);
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    checkOutput({name, " in_ready after start"}, int'(inReady[sel]), 1);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) checkOutput({name, " out_valid before last accept"}, int'(outValid[sel]), 0);
      inValid = 1'b1;
      inData  = ops[k];
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    inData  = 4'd0;
  endtask

  task automatic applyStimulus(input int sel, input int n, input logic [14:0][3:0] ops,
                               input int expMin, input int expIdx, input string name);
    collect(sel, n, ops, name);
    checkOutput({name, " out_valid"}, int'(outValid[sel]), 1);
    checkOutput({name, " in_ready in DONE"}, int'(inReady[sel]), 0);
    checkOutput({name, " busy in DONE"}, int'(busy[sel]), 1);
    checkOutput({name, " out_min"}, int'(outMin[sel]), expMin);
    checkOutput({name, " out_idx"}, int'(outIdx[sel]), expIdx);
    outAck = 1'b1;
    @(posedge clk); #1;
    outAck = 1'b0;
    checkOutput({name, " out_valid after ack"}, int'(outValid[sel]), 0);
    checkOutput({name, " busy after ack"}, int'(busy[sel]), 0);
  endtask

  initial begin
    int running [3];
    logic [14:0][3:0] ops;

    tbl[0] = '{mk4(9, 3, 7, 5),    3, 1, "basic"};
    tbl[1] = '{mk4(6, 2, 2, 15),   2, 1, "tie"};
    tbl[2] = '{mk4(0, 0, 0, 0),    0, 0, "zeros"};
    tbl[3] = '{mk4(15, 15, 15, 0), 0, 3, "last_min"};

    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = 4'd0;
    outAck   = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    start[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset in_ready", int'(inReady[0]), 0);
    checkOutput("reset busy", int'(busy[0]), 0);
    checkOutput("reset out_valid", int'(outValid[0]), 0);
    checkOutput("reset out_min", int'(outMin[0]), 0);
    checkOutput("reset out_idx", int'(outIdx[0]), 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 4, tbl[i].ops, tbl[i].expMin, tbl[i].expIdx, tbl[i].name);
    end

    // Bubbles: two idle cycles after each of the first three operands.
    ops        = mk4(8, 4, 1, 6);
    running[0] = 8;
    running[1] = 4;
    running[2] = 1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inValid = 1'b1;
      inData  = ops[k];
      @(posedge clk); #1;
      if (k < 3) begin
        inValid = 1'b0;
        inData  = 4'd0;
        for (int b = 0; b < 2; b++) begin
          checkOutput("bubble out_valid", int'(outValid[0]), 0);
          checkOutput("bubble cur", int'(outMin[0]), running[k]);
          @(posedge clk); #1;
        end
      end
    end
    inValid = 1'b0;
    inData  = 4'd0;
    checkOutput("bubble done out_valid", int'(outValid[0]), 1);
    checkOutput("bubble out_min", int'(outMin[0]), 1);
    checkOutput("bubble out_idx", int'(outIdx[0]), 2);
    outAck = 1'b1;
    @(posedge clk); #1;
    outAck = 1'b0;

    // Held result with start pulses in DONE and in the ack cycle.
    collect(0, 4, mk4(10, 11, 12, 13), "held");
    for (int c = 0; c < 10; c++) begin
      checkOutput("held out_valid", int'(outValid[0]), 1);
      start[0] = (c == 3);
      @(posedge clk); #1;
    end
    start[0] = 1'b0;
    outAck   = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    outAck   = 1'b0;
    start[0] = 1'b0;
    checkOutput("held ack out_valid", int'(outValid[0]), 0);
    checkOutput("held ack-cycle start ignored", int'(inReady[0]), 0);
    checkOutput("held ack busy", int'(busy[0]), 0);
    checkOutput("held min kept after ack", int'(outMin[0]), 10);
    applyStimulus(0, 4, mk4(1, 2, 3, 4), 1, 0, "restart");

    // Reset after two accepts, with an operand presented in the reset cycle.
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    inValid  = 1'b1;
    inData   = 4'd1;
    @(posedge clk); #1;
    inData   = 4'd2;
    @(posedge clk); #1;
    rst    = 1'b1;
    inData = 4'd3;
    @(posedge clk); #1;
    rst     = 1'b0;
    inValid = 1'b0;
    inData  = 4'd0;
    checkOutput("midreset in_ready", int'(inReady[0]), 0);
    checkOutput("midreset busy", int'(busy[0]), 0);
    checkOutput("midreset out_valid", int'(outValid[0]), 0);
    checkOutput("midreset out_min", int'(outMin[0]), 0);
    checkOutput("midreset out_idx", int'(outIdx[0]), 0);
    applyStimulus(0, 4, mk4(5, 9, 4, 12), 4, 2, "fresh");

    // Parameter sweep instances.
    applyStimulus(1, 2, mk4(7, 7, 0, 0), 7, 0, "n2");
    for (int k = 0; k < 15; k++) ops[k] = 4'(15 - k);
    applyStimulus(2, 15, ops, 1, 14, "n15");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/min_sequencer.md
# min_sequencer

Serial minimum finder that reuses a single two-input 4-bit min datapath (one `min_calculator_2num` instance) across a batch of `N` numbers streamed in one per cycle. A `start` pulse opens a batch. A valid/ready handshake accepts the operands. The block reports the zero-extended minimum and the index of the first occurrence of that minimum, and holds the result until the consumer acknowledges it. It sits between an operand source (register file or input FIFO) and a result consumer, replacing the fixed four-instance tree with a time-multiplexed, batch-length-parameterised controller.

## Interface

- `N`, default 4: numbers per batch; legal range 2..15.
- `W`, default 4: operand width; the datapath is fixed at 4, so only 4 is legal.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a batch; honoured only in IDLE.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_data` in W: operand.
- `in_ready` out 1: block accepts an operand this cycle.
- `busy` out 1: high in COLLECT and DONE.
- `out_valid` out 1: result available; high only in DONE.
- `out_min` out 2W: minimum, zero-extended (`{4'b0000, cur}`).
- `out_idx` out 4: 0-based batch index of the first occurrence of the minimum.
- `out_ack` in 1: consumer takes the result; meaningful only while `out_valid`=1.

## Operation

- FSM states: IDLE, COLLECT, DONE.
- Internal registers: `cur[3:0]`, `idx[3:0]`, `cnt[3:0]`.
- IDLE:
  - `in_ready`=0, `busy`=0, `out_valid`=0.
  - `start`=1 → COLLECT, with `cnt`←0.
- COLLECT:
  - `in_ready`=1, `busy`=1.
  - An operand is accepted on a cycle where `in_valid`&`in_ready`=1.
  - Accept with `cnt`=0: `cur`←`in_data`, `idx`←0.
  - Accept with `cnt`>0: the datapath compares `in_data` with `cur`.
    - If `in_data` < `cur` (strictly less, unsigned): `cur`←`in_data`, `idx`←`cnt`.
    - Otherwise both registers hold.
  - Each accept increments `cnt`.
  - Accept with `cnt`=N-1 → DONE.
  - `in_valid`=0 stalls the FSM; no state changes and `cnt` holds.
- DONE:
  - `in_ready`=0, `busy`=1, `out_valid`=1.
  - `out_min`/`out_idx` are driven from `cur`/`idx`.
  - `out_ack`=1 → IDLE.
- After ack, `out_min`/`out_idx` keep the last result until the next batch's first accept overwrites `cur`/`idx`. Consumers qualify them with `out_valid`.
- `start` is ignored in COLLECT and DONE; there is no restart mid-batch.
- Ties: equal values never replace `cur`, so `out_idx` reports the earliest index.
- `out_min[7:4]` is always 0.

## Timing

- All registers update on the rising edge of `clk`; `rst` is sampled on the same edge.
- Reset values: state=IDLE, `cur`=0, `idx`=0, `cnt`=0.
  - Resulting outputs: `in_ready`=0, `busy`=0, `out_valid`=0, `out_min`=8'h00, `out_idx`=0.
- `rst` has priority over every other input.
- Reset mid-batch or in DONE discards the partial or unacknowledged result. The block is in IDLE the cycle after reset.
- `start` sampled high in cycle t → `in_ready`=1 from cycle t+1.
- With `in_valid` held high, operands are accepted in cycles t+1..t+N. `out_valid`=1 from cycle t+N+1, so latency is N+1 cycles from `start`.
- `out_ack` sampled high in cycle d (with `out_valid`=1) → `out_valid`=0 from cycle d+1.
- Acking in the first DONE cycle is legal; minimum DONE residency is 1 cycle.
- A `start` in the same cycle as `out_ack` is ignored (state is DONE). The earliest honoured `start` is in cycle d+1.
- No combinational path from `out_ack` or `in_valid` to any output. `in_ready` depends on state only.

## Test plan

- Reset, N=4, then `start` and stream 9,3,7,5 with continuous `in_valid` → `out_valid` exactly 5 cycles after `start`; `out_min`=8'h03, `out_idx`=1; `in_ready` low in DONE.
- Ties and boundary values, stream 6,2,2,15 → `out_min`=8'h02, `out_idx`=1. Then stream 0,0,0,0 → `out_min`=8'h00, `out_idx`=0. Then 15,15,15,0 → `out_min`=8'h00, `out_idx`=3.
- Bubbles, stream 8,4,1,6 with `in_valid` low for 2 cycles between each operand → result `out_min`=8'h01, `out_idx`=2; `cnt` and `cur` unchanged during bubbles; `out_valid` after the 4th accept.
- Held result, no ack for 10 cycles then ack; `start` pulsed during DONE and in the ack cycle → `out_valid` held high 10 cycles, both `start`s ignored. A `start` one cycle after ack begins a new batch.
- Reset mid-operation, `rst` after 2 accepts, then a fresh batch 5,9,4,12 → IDLE with all outputs zero the cycle after reset; new result `out_min`=8'h04, `out_idx`=2, no carry-over from the aborted batch.
- Parameter sweep with N=2 (operands 7,7) and N=15 (descending 15..1) → 7/0 with latency 3; 1/14 with latency 16.
